// File: rtl/imem_loader.sv
// imem_loader: assembles a byte stream into 32-bit instruction words and writes them to instruction memory while holding the core in reset
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        checksum,
  output logic              core_hold
);
  localparam int LW = ADDR_W + 1;
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [1:0]        byte_q, byte_d;
  logic [31:0]       data_q, data_d;
  logic [LW-1:0]     len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic              done_q, done_d, err_q, err_d, hold_q, hold_d;
  logic              legal;
  assign legal     = load_len != '0 && load_len <= LW'(DEPTH);
  assign in_ready  = state_q == RECV;
  assign mem_we    = state_q == WRITE;
  assign busy      = state_q == RECV || state_q == WRITE;
  assign mem_waddr = word_q;
  assign mem_wdata = data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign checksum  = csum_q;
  assign core_hold = hold_q;
  // next-state: accept or reject a start, pack bytes little-endian, step through words
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    data_d  = data_q;
    len_d   = len_q;
    csum_d  = csum_q;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE, DONE: if (start) begin
        if (legal) begin
          state_d = RECV;
          word_d  = '0;
          byte_d  = '0;
          len_d   = load_len;
          csum_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      RECV: if (in_valid) begin
        data_d[8*byte_q +: 8] = in_data;
        csum_d  = csum_q + in_data;
        byte_d  = byte_q + 2'd1;
        state_d = byte_q == 2'd3 ? WRITE : RECV;
      end
      WRITE: if ({1'b0, word_q} == len_q - LW'(1)) begin
        state_d = DONE;
        done_d  = 1'b1;
        err_d   = 1'b0;
        hold_d  = 1'b0;
      end else begin
        state_d = RECV;
        word_d  = word_q + ADDR_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; reset aborts any load in flight and re-holds the core
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus with a write scoreboard for imem_loader
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  load_len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, mem_we, busy, done, err, core_hold;
  logic [7:0]  mem_waddr, checksum;
  logic [31:0] mem_wdata;
  logic [39:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .checksum(checksum), .core_hold(core_hold)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (mem_we !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_write got addr %0d data %h want none", mem_waddr, mem_wdata);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({mem_waddr, mem_wdata} !== e) begin
          errors++;
          $display("FAIL write got addr %0d data %h want addr %0d data %h", mem_waddr, mem_wdata, e[39:32], e[31:0]);
        end
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [8:0] len);
    start = 1'b1;
    load_len = len;
    tick();
    start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    logic t;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = b;
    do begin
      t = in_ready;
      tick();
      n++;
    end while (!t && n < 20);
    if (!t) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout got in_ready 0 want 1");
    end
    in_valid = 1'b0;
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("done_wait", done, 1);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_waddr"}, mem_waddr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_checksum"}, checksum, 0);
    chk({tag, "_core_hold"}, core_hold, 1);
  endtask
  initial begin
    logic [7:0] b, sum;
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();
    chk_reset_vals("idle");
    do_start(9'd0);
    chk("len0_err", err, 1);
    chk("len0_done", done, 1);
    chk("len0_hold", core_hold, 1);
    chk("len0_busy", busy, 0);
    tick();
    do_start(9'd257);
    chk("len257_err", err, 1);
    chk("len257_done", done, 1);
    chk("len257_hold", core_hold, 1);
    chk("len257_busy", busy, 0);
    chk("len257_checksum", checksum, 0);
    tick();
    do_start(9'd1);
    chk("w1_busy", busy, 1);
    chk("w1_err_clr", err, 0);
    chk("w1_done_clr", done, 0);
    exp_q.push_back({8'd0, 32'h0000_0013});
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("w1_we_after_4th", mem_we, 1);
    chk("w1_in_ready_write", in_ready, 0);
    wait_done();
    chk("w1_err", err, 0);
    chk("w1_hold", core_hold, 0);
    chk("w1_busy_done", busy, 0);
    chk("w1_checksum", checksum, 8'h13);
    chk("w1_in_ready_done", in_ready, 0);
    do_start(9'd3);
    chk("w3_hold", core_hold, 1);
    exp_q.push_back({8'd0, 32'h0403_0201});
    exp_q.push_back({8'd1, 32'h0807_0605});
    exp_q.push_back({8'd2, 32'h0C0B_0A09});
    for (int i = 1; i <= 12; i++) begin
      send_byte(8'(i));
      tick();
    end
    wait_done();
    chk("w3_checksum", checksum, 8'h4E);
    chk("w3_hold_done", core_hold, 0);
    do_start(9'd2);
    chk("reload_done", done, 0);
    chk("reload_err", err, 0);
    chk("reload_checksum", checksum, 0);
    chk("reload_hold", core_hold, 1);
    exp_q.push_back({8'd0, 32'hA3A2_A1A0});
    exp_q.push_back({8'd1, 32'hA7A6_A5A4});
    send_byte(8'hA0);
    send_byte(8'hA1);
    do_start(9'd1);
    chk("ign_start_busy", busy, 1);
    chk("ign_start_checksum", checksum, 8'h41);
    for (int i = 2; i < 8; i++) send_byte(8'(8'hA0 + i));
    wait_done();
    chk("ign_checksum", checksum, 8'h1C);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    do_start(9'd256);
    sum = '0;
    for (int w = 0; w < 256; w++) begin
      logic [31:0] d;
      for (int k = 0; k < 4; k++) begin
        b = 8'((4 * w + k) * 7 + 3);
        d[8*k +: 8] = b;
        sum = sum + b;
      end
      exp_q.push_back({8'(w), d});
      for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8]);
    end
    wait_done();
    chk("full_checksum", checksum, sum);
    chk("full_hold", core_hold, 0);
    chk("full_err", err, 0);
    do_start(9'd2);
    exp_q.push_back({8'd0, 32'h4433_2211});
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h77;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    chk_reset_vals("midrst");
    for (int i = 0; i < 8; i++) tick();
    chk("midrst_idle_busy", busy, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, 256, number of 32-bit instruction memory words.
REQ-002 Parameter: ADDR_W, 8, word address width; log2(DEPTH).
REQ-003 The block SHALL use one clock and a synchronous active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a load; sampled in IDLE and DONE only.
REQ-007 load_len  input  ADDR_W+1  number of words to load; sampled with start.
REQ-008 in_valid  input  1  byte-stream data valid.
REQ-009 in_data  input  8  byte-stream data.
REQ-010 in_ready  output  1  loader can accept a byte.
REQ-011 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-012 mem_waddr  output  ADDR_W  word index of the write.
REQ-013 mem_wdata  output  32  assembled instruction word.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  last load finished; held until next accepted start.
REQ-016 err  output  1  last start rejected because of an illegal length.
REQ-017 checksum  output  8  modulo-256 sum of all bytes accepted since last accepted start.
REQ-018 core_hold  output  1  holds the fetching core in reset while high.

Function
REQ-019 FSM states SHALL be IDLE, RECV, WRITE and DONE.
REQ-020 IDLE/DONE + start with 1 <= load_len <= DEPTH: clear word counter, byte counter, checksum, done and err; assert core_hold; go to RECV.
REQ-021 IDLE/DONE + start with load_len == 0 or load_len > DEPTH: set err=1 and done=1; go to DONE; no memory write; core_hold unchanged.
REQ-022 start in RECV or WRITE SHALL be ignored.
REQ-023 RECV: in_ready=1; a byte transfers on a cycle with in_valid && in_ready.
REQ-024 Bytes SHALL be packed little-endian: byte k of a word (k=0..3) goes to bits [8k+7:8k].
REQ-025 Each transferred byte SHALL be added to checksum modulo 256 in the same cycle.
REQ-026 After the 4th byte of a word is transferred, the FSM SHALL go to WRITE on the next cycle.
REQ-027 WRITE lasts exactly one cycle: mem_we=1, mem_waddr=word counter, mem_wdata=assembled word, in_ready=0.
REQ-028 Leaving WRITE: if word counter == load_len-1, go to DONE; else increment word counter and return to RECV.
REQ-029 Word counter SHALL run 0..load_len-1; it SHALL never wrap, and the maximum write address is DEPTH-1.
REQ-030 Entering DONE after a legal load: done=1, err=0, core_hold=0, busy=0.
REQ-031 busy SHALL be 1 exactly in RECV and WRITE.
REQ-032 in_ready SHALL be 1 only in RECV; mem_we SHALL be 1 only in WRITE.
REQ-033 Throughput SHALL be one word per 5 cycles when in_valid is held high.
REQ-034 in_valid gaps SHALL stall the assembly without losing or duplicating bytes.
REQ-035 mem_waddr and mem_wdata SHALL be don't-care when mem_we=0, but SHALL be driven to 0 out of reset.

Reset
REQ-036 Reset values SHALL be: state IDLE, in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, done=0, err=0, checksum=0, core_hold=1.
REQ-037 Reset in RECV or WRITE SHALL abort the load and discard any partial word; words already written are not rolled back.
REQ-038 Reset SHALL take priority over start and over any byte transfer in the same cycle.

Verification
REQ-039 Legal single-word load: start with load_len=1, then bytes 13,00,00,00 back-to-back -> exactly one mem_we with addr 0 and data 0x00000013; done=1; core_hold=0; checksum=0x13.
REQ-040 Legal 3-word load with in_valid toggling every other cycle, bytes 01..0C -> writes 0x04030201@0, 0x08070605@1, 0x0C0B0A09@2; no extra mem_we; checksum=0x4E.
REQ-041 Full-depth load: load_len=256 -> last write at addr 255; no write to addr 0 after the first; done=1.
REQ-042 Illegal lengths: load_len=0 -> err=1, done=1, no mem_we, core_hold stays 1; then load_len=257 -> same response.
REQ-043 Mid-load events: start pulsed in RECV -> ignored, load completes unchanged; reset asserted after 2 bytes of word 1 -> all outputs return to REQ-036 values and no write occurs for word 1.
REQ-044 Reload from DONE: a second start with load_len=2 -> done=0, err=0, checksum=0 and core_hold=1 the next cycle; writes restart at addr 0.
